// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_muldiv                                               |
// | Description : Handshaked ALU with single-cycle logic/arith ops plus an     |
// |               iterative unsigned shift-add multiplier and restoring        |
// |               divider (one bit per cycle). Results are fully registered.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         aluop,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_hi,
  output logic               zeroflag
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Shared iteration registers: acc_hi is partial product / remainder,
  // acc_lo is multiplier / dividend-turned-quotient, opb is multiplicand / divisor.
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Single-cycle result selection; divu here only covers the divide-by-zero case.
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    case (aluop)
      4'd0: alu_res = in1 + in2;
      4'd1: alu_res = in1 - in2;
      4'd2: alu_res = in1 & in2;
      4'd3: alu_res = in1 | in2;
      4'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'd5: alu_res = in2 << shamt;
      4'd6: alu_res = in2 >> shamt;
      4'd7: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      4'd9: begin
        alu_res = '1;
        alu_hi  = in1;
      end
      default: begin
        alu_res = '0;
        alu_hi  = '0;
      end
    endcase
  end

  // One shift-add multiply step: add multiplicand when the current multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, opb};
    if (acc_lo[0]) begin
      {mul_hi_nxt, mul_lo_nxt} = {mul_sum, acc_lo[WIDTH-1:1]};
    end else begin
      {mul_hi_nxt, mul_lo_nxt} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
  end

  // One restoring-division step: shift in next dividend bit, keep the difference if non-negative.
  always_comb begin
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opb};
    div_hi_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo_nxt = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (aluop == 4'd8) begin
            state_nxt = MUL;
          end else if ((aluop == 4'd9) && (in2 != '0)) begin
            state_nxt = DIV;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MUL:     if (last_iter) state_nxt = DONE;
      DIV:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, iteration and result registers; results only change on capture or final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      cnt      <= '0;
      out      <= '0;
      out_hi   <= '0;
      zeroflag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            zeroflag <= (in1 == in2);
            acc_hi   <= '0;
            acc_lo   <= in1;
            opb      <= in2;
            cnt      <= '0;
            if (state_nxt == DONE) begin
              out    <= alu_res;
              out_hi <= alu_hi;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          if (last_iter) begin
            cnt    <= '0;
            out    <= mul_lo_nxt;
            out_hi <= mul_hi_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          acc_hi <= div_hi_nxt;
          acc_lo <= div_lo_nxt;
          if (last_iter) begin
            cnt    <= '0;
            out    <= div_lo_nxt;
            out_hi <= div_hi_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_alu_muldiv                                            |
// | Description : Directed, table-driven self-checking bench for               |
// |               seq_alu_muldiv plus handshake/reset corner sequences.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] in1, in2;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out, out_hi;
  logic        zeroflag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] eo;
    logic [31:0] eh;
    logic        ez;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  seq_alu_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .in1       (in1),
    .in2       (in2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .zeroflag  (zeroflag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents a request, lets one rising edge accept it, returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    aluop    = op;
    in1      = a;
    in2      = b;
    shamt    = sh;
    in_valid = 1'b1;
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance until out_valid; flags in_ready seen high while busy.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL wait_valid_timeout: got out_valid=0 after %0d cycles expected 1", lat);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] eo, input logic [31:0] eh,
                         input logic ez, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.eo = eo; v.eh = eh; v.ez = ez; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit stable;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluop     = '0;
    in1       = '0;
    in2       = '0;
    shamt     = '0;

    //        op     in1            in2            sh   out            out_hi         zf  lat
    add_vec(4'd0, 32'd1,         32'd2,         5'd0, 32'd3,         32'd0,         0,  1);
    add_vec(4'd1, 32'd5,         32'd5,         5'd0, 32'd0,         32'd0,         1,  1);
    add_vec(4'd4, 32'hFFFFFFFD,  32'd5,         5'd0, 32'd1,         32'd0,         0,  1);
    add_vec(4'd7, 32'hFFFFFFFD,  32'd5,         5'd0, 32'd0,         32'd0,         0,  1);
    add_vec(4'd4, 32'd5,         32'hFFFFFFFD,  5'd0, 32'd0,         32'd0,         0,  1);
    add_vec(4'd5, 32'd0,         32'd20,        5'd1, 32'd40,        32'd0,         0,  1);
    add_vec(4'd6, 32'd0,         32'h80000000,  5'd31, 32'd1,        32'd0,         0,  1);
    add_vec(4'd2, 32'hF0F01234,  32'h0FF0FF00,  5'd0, 32'h00F01200,  32'd0,         0,  1);
    add_vec(4'd3, 32'hF0F01234,  32'h0FF0FF00,  5'd0, 32'hFFF0FF34,  32'd0,         0,  1);
    add_vec(4'd0, 32'hFFFFFFFF,  32'd1,         5'd0, 32'd0,         32'd0,         0,  1);
    add_vec(4'd1, 32'd0,         32'd1,         5'd0, 32'hFFFFFFFF,  32'd0,         0,  1);
    add_vec(4'd12, 32'd3,        32'd4,         5'd0, 32'd0,         32'd0,         0,  1);
    add_vec(4'd8, 32'hFFFFFFFF,  32'd2,         5'd0, 32'hFFFFFFFE,  32'd1,         0, 33);
    add_vec(4'd8, 32'h00010000,  32'h00010000,  5'd0, 32'd0,         32'd1,         1, 33);
    add_vec(4'd8, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd0, 32'd1,         32'hFFFFFFFE,  1, 33);
    add_vec(4'd9, 32'd100,       32'd7,         5'd0, 32'd14,        32'd2,         0, 33);
    add_vec(4'd9, 32'd7,         32'd100,       5'd0, 32'd0,         32'd7,         0, 33);
    add_vec(4'd9, 32'hFFFFFFFF,  32'd1,         5'd0, 32'hFFFFFFFF,  32'd0,         0, 33);
    add_vec(4'd9, 32'd9,         32'd0,         5'd0, 32'hFFFFFFFF,  32'd9,         0,  1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready",  {63'd0, in_ready},  64'd1);
    check("reset_out",       {32'd0, out},       64'd0);
    check("reset_out_hi",    {32'd0, out_hi},    64'd0);
    check("reset_zeroflag",  {63'd0, zeroflag},  64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      wait_valid(lat, busy_ok);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_out", i),     {32'd0, out},      {32'd0, vecs[i].eo});
      check($sformatf("v%0d_out_hi", i),  {32'd0, out_hi},   {32'd0, vecs[i].eh});
      check($sformatf("v%0d_zeroflag", i), {63'd0, zeroflag}, {63'd0, vecs[i].ez});
      if (vecs[i].lat > 1) check($sformatf("v%0d_busy_in_ready", i), {63'd0, busy_ok}, 64'd1);
      @(negedge clk);
    end

    // Backpressure: result held for 10 cycles while new requests are ignored.
    out_ready = 1'b0;
    issue(4'd0, 32'd7, 32'd8, 5'd0);
    wait_valid(lat, busy_ok);
    check("bp_latency", 64'(lat), 64'd1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      aluop    = 4'd0;
      in1      = 32'd100 + 32'(k);
      in2      = 32'd100 + 32'(k);
      in_valid = 1'b1;
      if (!out_valid || in_ready || out !== 32'd15 || out_hi !== 32'd0 || zeroflag !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", {63'd0, stable}, 64'd1);
    check("bp_out", {32'd0, out}, 64'd15);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
    stable = 1'b1;
    repeat (3) begin
      if (out_valid) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_no_queued_request", {63'd0, stable}, 64'd1);

    // Reset during multiply at iteration 16, with a competing request.
    issue(4'd8, 32'd5, 32'd3, 5'd0);
    repeat (15) @(negedge clk);
    rst      = 1'b1;
    aluop    = 4'd0;
    in1      = 32'd1;
    in2      = 32'd2;
    in_valid = 1'b1;
    @(negedge clk);
    check("rstmul_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstmul_out",       {32'd0, out},       64'd0);
    check("rstmul_out_hi",    {32'd0, out_hi},    64'd0);
    check("rstmul_zeroflag",  {63'd0, zeroflag},  64'd0);
    check("rstmul_in_ready",  {63'd0, in_ready},  64'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    stable   = 1'b1;
    repeat (40) begin
      if (out_valid) stable = 1'b0;
      @(negedge clk);
    end
    check("rstmul_no_result", {63'd0, stable}, 64'd1);
    issue(4'd0, 32'd1, 32'd2, 5'd0);
    wait_valid(lat, busy_ok);
    check("post_rst_latency", 64'(lat), 64'd1);
    check("post_rst_out", {32'd0, out}, 64'd3);
    @(negedge clk);

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    issue(4'd3, 32'h0000000F, 32'h000000F0, 5'd0);
    wait_valid(lat, busy_ok);
    check("done_out", {32'd0, out}, 64'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdone_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstdone_out",       {32'd0, out},       64'd0);
    check("rstdone_in_ready",  {63'd0, in_ready},  64'd1);
    out_ready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
